// File: rtl/mem_fault_classifier.sv
// Multi-pass RAM fault classifier: write/read-compare sweeps build a 2-bit per-word error map.
// Optional macro CHECKERBOARD_EN adds two checkerboard passes (4 passes instead of 2).
module mem_fault_classifier #(
  parameter int N_WORDS    = 64,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = $clog2(N_WORDS),
  parameter int MEM_RD_LAT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_data,
  output logic              busy,
  output logic              all_done,
  output logic [ADDR_W:0]   fault_count
);

`ifdef CHECKERBOARD_EN
  localparam int NPASS = 4;
  localparam logic [2*DATA_W-1:0] CB_WIDE = {DATA_W{2'b10}};
  localparam logic [DATA_W-1:0]   CB_A    = CB_WIDE[DATA_W-1:0];
`else
  localparam int NPASS = 2;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);
  localparam logic [1:0]        LAST_PASS = 2'(NPASS - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_pass;
  logic [1:0]        r_map [N_WORDS];
  logic [ADDR_W:0]   r_count;
  logic              r_cmp_valid;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic [DATA_W-1:0] r_cmp_pat;

  logic              w_start_ok;
  logic              w_last_addr;
  logic              w_last_pass;
  logic              w_next_pass;
  logic [DATA_W-1:0] w_pattern;
  logic              w_cmp_valid;
  logic [ADDR_W-1:0] w_cmp_addr;
  logic [DATA_W-1:0] w_cmp_pat;
  logic [1:0]        w_class;

  assign w_start_ok  = start && !abort && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last_addr = (r_addr == LAST_ADDR);
  assign w_last_pass = (r_pass == LAST_PASS);

  always_comb begin
`ifdef CHECKERBOARD_EN
    case (r_pass)
      2'd0:    w_pattern = '1;
      2'd1:    w_pattern = '0;
      2'd2:    w_pattern = r_addr[0] ? ~CB_A : CB_A;
      default: w_pattern = r_addr[0] ? CB_A : ~CB_A;
    endcase
`else
    w_pattern = r_pass[0] ? '0 : '1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_next_pass = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    busy        = 1'b0;
    all_done    = 1'b0;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next = S_WRITE;
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = w_pattern;
        busy      = 1'b1;
        if (abort)            w_next = S_IDLE;
        else if (w_last_addr) w_next = S_READ;
      end
      S_READ: begin
        mem_addr = r_addr;
        busy     = 1'b1;
        if (abort) w_next = S_IDLE;
        else if (w_last_addr) begin
          if (MEM_RD_LAT != 0) w_next = S_DRAIN;
          else if (w_last_pass) w_next = S_DONE;
          else begin
            w_next      = S_WRITE;
            w_next_pass = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (abort) w_next = S_IDLE;
        else if (w_last_pass) w_next = S_DONE;
        else begin
          w_next      = S_WRITE;
          w_next_pass = 1'b1;
        end
      end
      S_DONE: begin
        all_done = 1'b1;
        if (w_start_ok) w_next = S_WRITE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Registered-read RAMs return data one cycle late, so compare against the delayed address/pattern.
  always_comb begin
    if (MEM_RD_LAT != 0) begin
      w_cmp_valid = r_cmp_valid;
      w_cmp_addr  = r_cmp_addr;
      w_cmp_pat   = r_cmp_pat;
    end else begin
      w_cmp_valid = (r_state == S_READ);
      w_cmp_addr  = r_addr;
      w_cmp_pat   = w_pattern;
    end
    w_class = {|(~w_cmp_pat & mem_rdata), |(w_cmp_pat & ~mem_rdata)};
  end

  // NOTE: the error map is a reset flop array rather than a RAM because reset must clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_pass      <= '0;
      r_count     <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_addr  <= '0;
      r_cmp_pat   <= '0;
      for (int i = 0; i < N_WORDS; i++) r_map[i] <= 2'b00;
    end else begin
      r_cmp_valid <= (r_state == S_READ) && !abort;
      r_cmp_addr  <= r_addr;
      r_cmp_pat   <= w_pattern;
      if (w_start_ok) begin
        r_addr  <= '0;
        r_pass  <= '0;
        r_count <= '0;
        for (int i = 0; i < N_WORDS; i++) r_map[i] <= 2'b00;
      end else begin
        if (abort || !busy)
          r_addr <= '0;
        else if (r_state == S_WRITE || r_state == S_READ)
          r_addr <= w_last_addr ? '0 : r_addr + 1'b1;
        if (w_next_pass) r_pass <= r_pass + 2'd1;
        // A compare in the abort cycle is dropped along with the test.
        if (w_cmp_valid && !abort) begin
          r_map[w_cmp_addr] <= r_map[w_cmp_addr] | w_class;
          if (r_map[w_cmp_addr] == 2'b00 && w_class != 2'b00) r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign rd_data     = (32'(rd_addr) < N_WORDS) ? r_map[rd_addr] : 2'b00;
  assign fault_count = r_count;

endmodule

// File: tb/tb_mem_fault_classifier.sv
// Scoreboard bench for mem_fault_classifier: LAT0 and LAT1 instances, each with a faultable RAM model.
module tb_mem_fault_classifier;

`ifdef CHECKERBOARD_EN
  localparam int NPASS = 4;
`else
  localparam int NPASS = 2;
`endif
  localparam int LAT0 = 2 * 8 * NPASS;
  localparam int LAT1 = 2 * 8 * NPASS + NPASS;

  typedef struct packed {
    logic        sel;
    logic [15:0] map;
    logic [3:0]  cnt;
    int          lat;
  } item_t;

  logic clk = 1'b0;
  logic reset, start0, start1, abort0, abort1;
  logic [2:0] rd_addr;
  logic        we0, we1, busy0, busy1, done0, done1;
  logic [2:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1, rdata0, rdata1;
  logic [1:0]  rd0, rd1;
  logic [3:0]  cnt0, cnt1;

  logic [15:0] mem0 [8];
  logic [15:0] mem1 [8];
  logic [15:0] sa0_m [8];
  logic [15:0] sa1_m [8];

  item_t sb_q[$];
  int    cyc = 0;
  int    start_cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  logic  mon_busy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_fault_classifier #(.N_WORDS(8), .DATA_W(16), .MEM_RD_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0),
    .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0), .mem_rdata(rdata0),
    .rd_addr(rd_addr), .rd_data(rd0), .busy(busy0), .all_done(done0), .fault_count(cnt0));

  mem_fault_classifier #(.N_WORDS(8), .DATA_W(16), .MEM_RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1),
    .rd_addr(rd_addr), .rd_data(rd1), .busy(busy1), .all_done(done1), .fault_count(cnt1));

  // RAM models: stuck bits are applied on the read path.
  always @(posedge clk) if (we0) mem0[addr0] <= wdata0;
  always @(posedge clk) if (we1) mem1[addr1] <= wdata1;
  always_comb rdata0 = (mem0[addr0] & ~sa0_m[addr0]) | sa1_m[addr0];
  always @(posedge clk) rdata1 <= (mem1[addr1] & ~sa0_m[addr1]) | sa1_m[addr1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 8; i++) begin
      sa0_m[i] = 16'h0000;
      sa1_m[i] = 16'h0000;
    end
  endtask

  task automatic pulse_start(input logic sel);
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    check("busy after start", sel ? busy1 : busy0, 1);
    check("count cleared at start", sel ? cnt1 : cnt0, 0);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic run_scn(input logic sel, input logic [15:0] emap, input logic [3:0] ecnt,
                         input int elat);
    int k;
    item_t it;
    it.sel = sel; it.map = emap; it.cnt = ecnt; it.lat = elat;
    sb_q.push_back(it);
    pulse_start(sel);
    k = 0;
    while (!(sel ? done1 : done0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      check("all_done timeout", 0, 1);
      sb_q.delete();
    end
    k = 0;
    while ((sb_q.size() != 0 || mon_busy) && k < 50) begin
      @(posedge clk);
      k++;
    end
    if (k >= 50) begin
      check("scoreboard drain timeout", 0, 1);
      sb_q.delete();
    end
  endtask

  // Monitor: on each all_done rising edge pop the expected result and read the whole map back.
  initial begin
    logic  prev0, prev1, sel;
    item_t it;
    rd_addr = '0;
    prev0   = 1'b0;
    prev1   = 1'b0;
    forever begin
      @(negedge clk);
      if ((done0 && !prev0) || (done1 && !prev1)) begin
        mon_busy = 1'b1;
        sel = done1 && !prev1;
        if (sb_q.size() == 0) check("unexpected all_done", 1, 0);
        else begin
          it = sb_q.pop_front();
          check("instance", sel, it.sel);
          check("latency", cyc - start_cyc, it.lat);
          check("fault_count", sel ? cnt1 : cnt0, it.cnt);
          for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check($sformatf("map[%0d]", i), sel ? rd1 : rd0, it.map[2*i +: 2]);
          end
        end
        mon_busy = 1'b0;
      end
      prev0 = done0;
      prev1 = done1;
    end
  end

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
    clear_faults();
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy0, 0);
    check("reset all_done", done0, 0);
    check("reset mem_we", we0, 0);
    check("reset mem_addr", addr0, 0);
    check("reset mem_wdata", wdata0, 0);
    check("reset fault_count", cnt0, 0);
    check("reset all_done lat1", done1, 0);
    @(negedge clk);
    reset = 1'b0;

    // Fault-free RAM.
    run_scn(1'b0, 16'h0000, 4'd0, LAT0);
    // Word 5 bit 3 stuck-at-0.
    clear_faults(); sa0_m[5] = 16'h0008;
    run_scn(1'b0, 16'h0400, 4'd1, LAT0);
    // Word 2 bit 0 stuck-at-1, word 7 bit 15 stuck-at-0.
    clear_faults(); sa1_m[2] = 16'h0001; sa0_m[7] = 16'h8000;
    run_scn(1'b0, 16'h4020, 4'd2, LAT0);
    // Word 4 bit 1 stuck-at-1 and bit 9 stuck-at-0.
    clear_faults(); sa1_m[4] = 16'h0002; sa0_m[4] = 16'h0200;
    run_scn(1'b0, 16'h0300, 4'd1, LAT0);

    // Abort mid-READ with start also high: back to IDLE, partial map kept.
    clear_faults(); sa0_m[1] = 16'h0004;
    pulse_start(1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    abort0 = 1'b1; start0 = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", busy0, 0);
    check("abort mem_we", we0, 0);
    check("abort all_done", done0, 0);
    check("abort keeps count", cnt0, 1);
    @(posedge clk);
    #1;
    check("start with abort ignored", busy0, 0);
    @(negedge clk);
    abort0 = 1'b0; start0 = 1'b0;
    clear_faults();
    run_scn(1'b0, 16'h0000, 4'd0, LAT0);

    // Registered-read RAM, word 6 bit 0 stuck-at-0.
    clear_faults(); sa0_m[6] = 16'h0001;
    run_scn(1'b1, 16'h1000, 4'd1, LAT1);

    // Asynchronous reset in the middle of READ.
    clear_faults(); sa0_m[1] = 16'h0004;
    pulse_start(1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("pre-reset busy", busy0, 1);
    check("pre-reset count", cnt0, 1);
    #1;
    reset = 1'b1;
    #1;
    check("async reset busy", busy0, 0);
    check("async reset mem_addr", addr0, 0);
    check("async reset mem_we", we0, 0);
    check("async reset count", cnt0, 0);
    check("async reset all_done", done0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
